// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding, PC step and default reset/trap vectors
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, ISSUE, FLUSH} fetch_state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_PC = 32'h0000_0010;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem req/addr/ack/rdata + decode valid/instr/instr_pc/ready; master=sequencer, slave=memory/decode
interface fetch_sequencer_if #(parameter int XLEN = 32);
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic instr_ready;
  modport master(output imem_req, imem_addr, instr_valid, instr, instr_pc, input imem_ack, imem_rdata, instr_ready);
  modport slave(input imem_req, imem_addr, instr_valid, instr, instr_pc, output imem_ack, imem_rdata, instr_ready);
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch PC register (clk, clr_n, load_en/load_pc, inc_en -> pc); load wins over increment, wraps mod 2^XLEN
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) pc <= RESET_PC;
    else if (load_en) pc <= load_pc;
    else if (inc_en) pc <= pc + XLEN'(PC_STEP);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch FSM (clk, clr_n, redirect_en/pc, stall, bus=fetch_sequencer_if.master, misalign_trap when MISALIGN_TRAP_EN)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
`ifdef MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_PC = XLEN'(DEF_TRAP_PC)
`endif
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     redirect_en,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     stall,
  fetch_sequencer_if.master        bus
`ifdef MISALIGN_TRAP_EN
  , output logic                   misalign_trap
`endif
);
  fetch_state_t state, next_state;
  logic [XLEN-1:0] pc, stale_addr, target;
  logic req_q, ack, capture;
  assign ack = bus.imem_ack && req_q;
  assign capture = !redirect_en && state == FETCH && ack;
`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign target = misaligned ? TRAP_PC : redirect_pc & ~XLEN'(3);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) misalign_trap <= 1'b0;
    else misalign_trap <= redirect_en && misaligned;
`else
  assign target = redirect_pc & ~XLEN'(3);
`endif
  fetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk,
    .clr_n,
    .load_en(redirect_en),
    .load_pc(target),
    .inc_en(capture),
    .pc
  );
  // A redirect with a request still in flight must drain it in FLUSH rather than drop it.
  always_comb begin
    next_state = state;
    if (redirect_en) next_state = (state != ISSUE && !ack) ? FLUSH : FETCH;
    else if (state == FETCH) next_state = ack ? ISSUE : FETCH;
    else if (state == ISSUE) next_state = (bus.instr_ready && !stall) ? FETCH : ISSUE;
    else next_state = ack ? FETCH : FLUSH;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= FETCH;
      req_q <= 1'b0;
      stale_addr <= '0;
      bus.instr <= '0;
      bus.instr_pc <= '0;
    end else begin
      state <= next_state;
      req_q <= next_state != ISSUE;
      if (state == FETCH && next_state == FLUSH) stale_addr <= pc;
      if (capture) begin
        bus.instr <= bus.imem_rdata;
        bus.instr_pc <= pc;
      end
    end
  assign bus.imem_req = req_q;
  assign bus.imem_addr = state == FLUSH ? stale_addr : pc;
  assign bus.instr_valid = state == ISSUE;
endmodule
